// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the uart_tx serializer through its one-cycle enable / busy handshake.
// Optional CR insertion before each LF is enabled by defining UART_TX_FIFO_CRLF_EN.
module uart_tx_fifo #(
    parameter int DEPTH_LOG2   = 4,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    input  logic                  overflow_clr,
    output logic                  uart_en,
    output logic [7:0]            uart_data,
    input  logic                  uart_busy
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_reg;
    logic [DEPTH_LOG2-1:0] rd_ptr_reg;
    logic [DEPTH_LOG2:0]   level_reg;
    logic                  overflow_reg;
    logic                  uart_en_reg;
    logic [7:0]            uart_data_reg;
    logic [CW-1:0]         cnt_reg;
    state_t                state_reg;

    logic       push_ok;
    logic       launch;
    logic       pop;
    logic [7:0] head;
    logic [7:0] launch_byte;

    assign full      = (level_reg == (DEPTH_LOG2+1)'(DEPTH));
    assign empty     = (level_reg == '0);
    assign level     = level_reg;
    assign overflow  = overflow_reg;
    assign uart_en   = uart_en_reg;
    assign uart_data = uart_data_reg;

    assign head    = mem[rd_ptr_reg];
    assign push_ok = wr_en && !full;
    assign launch  = (state_reg == IDLE) && !empty && !uart_busy;

`ifdef UART_TX_FIFO_CRLF_EN
    logic crlf_sent_reg;
    logic insert_cr;

    // A CR is launched ahead of the LF while the LF stays at the head.
    assign insert_cr   = launch && (head == 8'h0A) && !crlf_sent_reg;
    assign pop         = launch && !insert_cr;
    assign launch_byte = insert_cr ? 8'h0D : head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crlf_sent_reg <= 1'b0;
        end else if (insert_cr) begin
            crlf_sent_reg <= 1'b1;
        end else if (pop) begin
            crlf_sent_reg <= 1'b0;
        end
    end
`else
    assign pop         = launch;
    assign launch_byte = head;
`endif

    // Storage carries no reset; contents are only meaningful below level.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + DEPTH_LOG2'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + DEPTH_LOG2'(1);
            end
            case ({push_ok, pop})
                2'b10:   level_reg <= level_reg + (DEPTH_LOG2+1)'(1);
                2'b01:   level_reg <= level_reg - (DEPTH_LOG2+1)'(1);
                default: level_reg <= level_reg;
            endcase
            // A dropped push takes priority over a clear in the same cycle.
            if (wr_en && full) begin
                overflow_reg <= 1'b1;
            end else if (overflow_clr) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            uart_en_reg   <= 1'b0;
            uart_data_reg <= 8'h00;
        end else begin
            uart_en_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (launch) begin
                        uart_data_reg <= launch_byte;
                        uart_en_reg   <= 1'b1;
                        cnt_reg       <= '0;
                        state_reg     <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    // Give up on a serializer that never acknowledges.
                    if (uart_busy) begin
                        state_reg <= WAIT_DONE;
                    end else if (cnt_reg == CW'(BUSY_TIMEOUT - 1)) begin
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!uart_busy) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte FIFO between the memory controller's UART TX write port and the uart_tx serializer.
- Lets the core post a burst of characters without stalling on every byte. The core stalls only when the FIFO is full.
- Drains one byte at a time into uart_tx using uart_tx's single-cycle enable / busy handshake.

Parameters:
- DEPTH_LOG2, 4: log2 of FIFO depth. Depth = 2**DEPTH_LOG2 = 16 entries by default. Legal range 1..8.
- BUSY_TIMEOUT, 4: cycles to wait for uart_busy to rise after a launch before returning to IDLE. Minimum 1.

Ports:
- clk, input, 1: system clock, shared with core and mem_ctl.
- rst_n, input, 1: asynchronous active-low reset.
- wr_en, input, 1: push strobe from mem_ctl (its uart_tx_en).
- wr_data, input, 8: byte to push (mem_ctl uart_tx_data).
- full, output, 1: FIFO full; drives mem_ctl uart_tx_busy.
- empty, output, 1: FIFO empty.
- level, output, DEPTH_LOG2+1: current entry count, 0..DEPTH.
- overflow, output, 1: sticky; set when a push was dropped.
- overflow_clr, input, 1: synchronous clear of overflow.
- uart_en, output, 1: one-cycle launch strobe to uart_tx uart_tx_en.
- uart_data, output, 8: byte to uart_tx uart_tx_data; held stable from launch until the next launch.
- uart_busy, input, 1: from uart_tx uart_tx_busy.

Behaviour:
- Reset (async, rst_n=0): all outputs take their reset values immediately.
  - Read/write pointers, level = 0; empty = 1; full = 0; overflow = 0.
  - uart_en = 0; uart_data = 8'h00; FSM = IDLE; timeout counter = 0.
  - Reset mid-transfer discards FIFO contents. Any byte already in uart_tx is not recalled.
- Storage: register array of DEPTH x 8.
  - Pointers are DEPTH_LOG2 bits and wrap modulo DEPTH.
  - level is tracked separately. full = (level == DEPTH); empty = (level == 0). Both are registered / derived from registered level.
- Push:
  - wr_en=1 with full=0: wr_data is written at the edge, wr_ptr increments, level increments.
  - wr_en=1 with full=1: byte dropped, no pointer change, overflow <= 1.
- Pop: occurs only on an FSM launch edge.
- Simultaneous push and pop in one edge (not full): both happen, level unchanged.
  - On full with simultaneous pop, the push is still dropped, because full is the registered state at the start of the cycle.
- overflow_clr=1 clears overflow. If overflow_clr and a dropped push coincide, set wins.
- Drain FSM states: IDLE, WAIT_BUSY, WAIT_DONE.
  - IDLE: if empty=0 and uart_busy=0, then at the next edge: pop head into uart_data, uart_en <= 1, timeout counter <= 0, go to WAIT_BUSY. Otherwise stay.
  - WAIT_BUSY: uart_en <= 0 at the first edge, so uart_en is high for exactly one cycle.
    - uart_busy=1: go to WAIT_DONE.
    - Otherwise increment the counter. When the counter reaches BUSY_TIMEOUT-1 with no busy, go to IDLE.
  - WAIT_DONE: uart_busy=0 -> IDLE.
- Latency: a push at edge E into an empty FIFO with uart_busy=0 gives level=1 after E. uart_en is high from edge E+1 to E+2.
- Back-to-back bytes: the minimum gap between launches is the uart_tx frame time plus 2 cycles.
- mem_ctl sees full as busy. Any write while not full completes in one cycle.

Optional Feature:
- Macro UART_TX_FIFO_CRLF_EN.
- Defined: adds a crlf_sent flag (reset 0).
  - In IDLE, if the head byte is 8'h0A and crlf_sent=0, launch 8'h0D without popping and set crlf_sent.
  - The next launch pops and sends 8'h0A and clears crlf_sent.
  - level and full count stored bytes only; the inserted 8'h0D does not occupy an entry.
- Not defined: bytes are sent verbatim and the flag logic is absent.

Test Plan:
- Reset: hold rst_n=0 mid-WAIT_DONE with level=5 -> immediately level=0, empty=1, uart_en=0, FSM IDLE. After release, no launch occurs.
- Single byte: push 8'h41 at edge E with uart_busy=0 -> uart_en=1 for exactly one cycle (E+1..E+2) with uart_data=8'h41, then level=0.
- Fill/overflow: hold uart_busy=1 and push 17 bytes 0x00..0x10 (DEPTH=16) -> full=1 after the 16th, 17th dropped, overflow=1. Release busy -> launches 0x00..0x0F in order. overflow_clr -> overflow=0.
- Wrap and simultaneous events: push/pop interleaved across 40 bytes with a pop coinciding with a push -> level unchanged on coincident edges, output order matches input order across pointer wrap.
- Busy timeout: uart_busy tied 0 -> each launch returns to IDLE after BUSY_TIMEOUT cycles and the next byte is launched; no hang.
- CRLF (UART_TX_FIFO_CRLF_EN defined): push 8'h48, 8'h0A -> launches 8'h48, 8'h0D, 8'h0A. Without the macro -> 8'h48, 8'h0A.
